seq_det_sched: RTL and testbench

- Round-robin scheduler that shares one bit-serial 4-bit pattern detector between two parallel-word requesters.
- Each accepted word is shifted MSB-first through the detector, one bit per clock.
- The detector pattern and overlap mode are programmable.
- At word end the block reports the match count and the requester ID.
- It sits in the FSM sequence-detector group, in front of serial-pattern consumers.

---
 rtl/seq_det_sched.sv | 142 ++++++++++++++
 tb/tb_seq_det_sched.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/seq_det_sched.sv
// Round-robin scheduler sharing one bit-serial 4-bit pattern detector between
// two parallel-word requesters; reports match count and requester ID per word.
module seq_det_sched #(
  parameter int unsigned W     = 8,
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [W-1:0]     req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [W-1:0]     req1_data,
  output logic             req1_ready,
  input  logic [3:0]       cfg_pattern,
  input  logic             cfg_overlap,
  output logic             busy,
  output logic             bit_valid,
  output logic             bit_out,
  output logic             match,
  output logic             done_valid,
  output logic             done_id,
  output logic [CNT_W-1:0] done_count
);

  localparam int unsigned IDX_W = (W > 1) ? $clog2(W) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state, state_nxt;
  logic             rr_last;
  logic             grant_id;
  logic             accept;
  logic [W-1:0]     sreg;
  logic             cur_id;
  logic [3:0]       pat;
  logic             ovl;
  logic [2:0]       hist;
  logic [2:0]       fill;
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] bit_idx;

  logic             cur_bit;
  logic [3:0]       hist_nxt;
  logic [2:0]       fill_inc;
  logic [2:0]       fill_nxt;
  logic             hit;
  logic [CNT_W-1:0] cnt_nxt;
  logic             last_bit;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Arbitration and next-state; only the oldest-loser wins a tie
  always_comb begin
    state_nxt  = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    accept     = 1'b0;
    grant_id   = (req0_valid && req1_valid) ? ~rr_last : req1_valid;
    case (state)
      IDLE: begin
        req0_ready = req0_valid && !grant_id;
        req1_ready = req1_valid && grant_id;
        accept     = req0_ready || req1_ready;
        if (accept) state_nxt = SHIFT;
      end
      SHIFT: if (last_bit) state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Detector step for the bit currently at the head of the shift register
  always_comb begin
    cur_bit  = sreg[W-1];
    hist_nxt = {hist, cur_bit};
    fill_inc = (fill == 3'd4) ? 3'd4 : fill + 3'd1;
    hit      = (fill_inc == 3'd4) && (hist_nxt == pat);
    fill_nxt = (hit && !ovl) ? 3'd0 : fill_inc;
    cnt_nxt  = (hit && (cnt != CNT_MAX)) ? cnt + CNT_W'(1) : cnt;
    last_bit = (bit_idx == IDX_W'(W - 1));
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_last    <= 1'b1;
      sreg       <= '0;
      cur_id     <= 1'b0;
      pat        <= '0;
      ovl        <= 1'b0;
      hist       <= '0;
      fill       <= '0;
      cnt        <= '0;
      bit_idx    <= '0;
      busy       <= 1'b0;
      bit_valid  <= 1'b0;
      bit_out    <= 1'b0;
      match      <= 1'b0;
      done_valid <= 1'b0;
      done_id    <= 1'b0;
      done_count <= '0;
    end else begin
      busy       <= (state_nxt != IDLE);
      bit_valid  <= 1'b0;
      bit_out    <= 1'b0;
      match      <= 1'b0;
      done_valid <= 1'b0;
      if (accept) begin
        sreg    <= grant_id ? req1_data : req0_data;
        cur_id  <= grant_id;
        rr_last <= grant_id;
        pat     <= cfg_pattern;
        ovl     <= cfg_overlap;
        hist    <= '0;
        fill    <= '0;
        cnt     <= '0;
        bit_idx <= '0;
      end else if (state == SHIFT) begin
        sreg      <= {sreg[W-2:0], 1'b0};
        hist      <= hist_nxt[2:0];
        fill      <= fill_nxt;
        cnt       <= cnt_nxt;
        bit_idx   <= bit_idx + IDX_W'(1);
        bit_valid <= 1'b1;
        bit_out   <= cur_bit;
        match     <= hit;
        if (last_bit) begin
          done_valid <= 1'b1;
          done_id    <= cur_id;
          done_count <= cnt_nxt;
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_det_sched.sv
// Scoreboard bench for seq_det_sched: driver pushes expected per-word results,
// monitor pops and compares on every done_valid.
module tb_seq_det_sched;

  localparam int unsigned W     = 8;
  localparam int unsigned CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             req0_valid = 1'b0;
  logic [W-1:0]     req0_data  = '0;
  logic             req0_ready;
  logic             req1_valid = 1'b0;
  logic [W-1:0]     req1_data  = '0;
  logic             req1_ready;
  logic [3:0]       cfg_pattern = 4'b0110;
  logic             cfg_overlap = 1'b0;
  logic             busy, bit_valid, bit_out, match, done_valid, done_id;
  logic [CNT_W-1:0] done_count;

  seq_det_sched #(.W(W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .cfg_pattern(cfg_pattern), .cfg_overlap(cfg_overlap),
    .busy(busy), .bit_valid(bit_valid), .bit_out(bit_out), .match(match),
    .done_valid(done_valid), .done_id(done_id), .done_count(done_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic             id;
    logic [W-1:0]     data;
    logic [W-1:0]     mask;
    logic [CNT_W-1:0] cnt;
    int               acc;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: collect bit stream and match positions, compare at word end
  logic [W-1:0] got_bits, got_mask;
  int           got_n;
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      got_bits = '0; got_mask = '0; got_n = 0;
    end else begin
      if (bit_valid) begin
        got_bits = {got_bits[W-2:0], bit_out};
        got_mask = {got_mask[W-2:0], match};
        got_n++;
      end
      if (done_valid) begin
        if (q.size() == 0) begin
          chk("unexpected_done", 32'(done_valid), 32'd0);
        end else begin
          e = q.pop_front();
          chk("done_id",    32'(done_id),    32'(e.id));
          chk("done_count", 32'(done_count), 32'(e.cnt));
          chk("bit_stream", 32'(got_bits),   32'(e.data));
          chk("match_mask", 32'(got_mask),   32'(e.mask));
          chk("bit_count",  32'(got_n),      32'(W));
          chk("latency",    32'(cyc - e.acc), 32'(W));
        end
        got_bits = '0; got_mask = '0; got_n = 0;
      end
    end
  end

  task automatic push_exp(input logic id, input logic [W-1:0] data,
                          input logic [CNT_W-1:0] ecnt, input logic [W-1:0] emask,
                          input int acc);
    exp_t e;
    e.id = id; e.data = data; e.cnt = ecnt; e.mask = emask; e.acc = acc;
    q.push_back(e);
  endtask

  // Offer one word on one requester; returns just after the accept edge
  task automatic send(input logic id, input logic [W-1:0] data, input logic [3:0] pat,
                      input logic ovl, input logic [CNT_W-1:0] ecnt,
                      input logic [W-1:0] emask, input logic keep);
    bit got = 1'b0;
    @(posedge clk); #1;
    cfg_pattern = pat;
    cfg_overlap = ovl;
    if (id) begin req1_data = data; req1_valid = 1'b1; end
    else    begin req0_data = data; req0_valid = 1'b1; end
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if ((id && req1_ready) || (!id && req0_ready)) begin
        got = 1'b1;
        if (keep) push_exp(id, data, ecnt, emask, cyc + 1);
      end
    end
    if (!got) chk("accept_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  initial begin
    int k, prev, lim;
    logic gid;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_busy",       32'(busy),       32'd0);
    chk("rst_done_valid", 32'(done_valid), 32'd0);
    chk("rst_done_count", 32'(done_count), 32'd0);
    chk("rst_bit_valid",  32'(bit_valid),  32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("idle_ready0", 32'(req0_ready), 32'd0);

    // Non-overlap and overlap counts
    send(1'b0, 8'h66, 4'b0110, 1'b0, 4'd2, 8'h11, 1'b1);
    send(1'b1, 8'h6C, 4'b0110, 1'b1, 4'd2, 8'h12, 1'b1);
    send(1'b0, 8'h6C, 4'b0110, 1'b0, 4'd1, 8'h10, 1'b1);
    send(1'b1, 8'h00, 4'b0000, 1'b1, 4'd5, 8'h1F, 1'b1);
    send(1'b0, 8'h00, 4'b0000, 1'b0, 4'd2, 8'h11, 1'b1);
    send(1'b1, 8'h66, 4'b0110, 1'b1, 4'd2, 8'h11, 1'b1);

    // Config change mid-word is ignored; next word uses the new pattern
    send(1'b0, 8'h66, 4'b0110, 1'b0, 4'd2, 8'h11, 1'b1);
    repeat (2) @(posedge clk); #1;
    cfg_pattern = 4'b1111;
    send(1'b1, 8'h0F, 4'b1111, 1'b0, 4'd1, 8'h01, 1'b1);

    // Reset at bit 3 of a word: dropped, outputs clear asynchronously
    send(1'b0, 8'h66, 4'b0110, 1'b0, 4'd0, 8'h00, 1'b0);
    repeat (3) @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("mid_rst_busy",       32'(busy),       32'd0);
    chk("mid_rst_bit_valid",  32'(bit_valid),  32'd0);
    chk("mid_rst_done_valid", 32'(done_valid), 32'd0);
    chk("mid_rst_done_id",    32'(done_id),    32'd0);
    chk("mid_rst_done_count", 32'(done_count), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Round robin with both valid held: grants 0,1,0,1 spaced W+2 cycles
    @(posedge clk); #1;
    cfg_pattern = 4'b0110;
    cfg_overlap = 1'b1;
    req0_data = 8'h66;
    req1_data = 8'h6C;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    k = 0; prev = 0; lim = 0;
    while (k < 4 && lim < 100) begin
      @(negedge clk);
      lim++;
      if (req0_ready || req1_ready) begin
        chk("rr_onehot", 32'(req0_ready & req1_ready), 32'd0);
        gid = req1_ready;
        chk("rr_grant", 32'(gid), 32'(k % 2));
        if (k > 0) chk("rr_spacing", 32'(cyc - prev), 32'(W + 2));
        prev = cyc;
        if (gid) push_exp(1'b1, 8'h6C, 4'd2, 8'h12, cyc + 1);
        else     push_exp(1'b0, 8'h66, 4'd2, 8'h11, cyc + 1);
        k++;
      end
    end
    if (k < 4) chk("rr_timeout", 32'(k), 32'd4);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;

    // Drain
    lim = 0;
    while ((q.size() != 0 || busy) && lim < 200) begin
      @(negedge clk);
      lim++;
    end
    chk("drain_queue", 32'(q.size()), 32'd0);
    chk("drain_busy",  32'(busy),     32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
